// File: rtl/user_insn_dispatch_pkg.sv
// Shared definitions for the LM32 user-instruction dispatcher: FSM state
// encodings, fixed bus widths, the default error result and the unit-select
// field width helper.
package user_insn_dispatch_pkg;

  localparam int unsigned OPCODE_W  = 11;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ERR_CNT_W = 8;
  localparam int unsigned TIMER_W   = 16;
  localparam int unsigned STATE_W   = 2;

  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE    = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP     = 2'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_LOW = 2'd3;

  localparam logic [DATA_W-1:0] ERR_RESULT_DEFAULT = 32'hDEAD_BEEF;

  // Width of the unit-select field; a single unit still gets one bit.
  function automatic int unsigned sel_width(input int unsigned num_units);
    return (num_units <= 2) ? 1 : $clog2(num_units);
  endfunction

endpackage

// File: rtl/user_insn_dispatch.sv
// user_insn_dispatch
//   Sequences the LM32 user-instruction port onto NUM_UNITS accelerator units.
//   A unit index is decoded from the opcode, a req/ack transaction is run
//   against that unit and its result is handed back to the CPU as a one-cycle
//   completion pulse. Unmapped opcodes and units that never ack return
//   ERR_RESULT and bump a saturating error counter.
// Ports
//   clk, rst                      clock, async active-high reset
//   user_valid/opcode/operand_0/1 CPU request (level, held until complete)
//   user_result, user_complete    CPU response (result zero outside the pulse)
//   unit_req                      one-hot request, held until ack or timeout
//   unit_opcode, unit_op0/1       sub-opcode and operands latched at issue
//   unit_ack, unit_result         per-unit ack pulse and result bus
//   busy                          dispatcher not idle
//   err_count                     saturating timeout + unmapped count
module user_insn_dispatch
  import user_insn_dispatch_pkg::*;
#(
  parameter int unsigned       NUM_UNITS  = 4,
  parameter int unsigned       SEL_LSB    = 7,
  parameter int unsigned       TIMEOUT    = 1023,
  parameter logic [DATA_W-1:0] ERR_RESULT = ERR_RESULT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        user_valid,
  input  logic [OPCODE_W-1:0]         user_opcode,
  input  logic [DATA_W-1:0]           user_operand_0,
  input  logic [DATA_W-1:0]           user_operand_1,
  output logic [DATA_W-1:0]           user_result,
  output logic                        user_complete,
  output logic [NUM_UNITS-1:0]        unit_req,
  output logic [SEL_LSB-1:0]          unit_opcode,
  output logic [DATA_W-1:0]           unit_op0,
  output logic [DATA_W-1:0]           unit_op1,
  input  logic [NUM_UNITS-1:0]        unit_ack,
  input  logic [DATA_W*NUM_UNITS-1:0] unit_result,
  output logic                        busy,
  output logic [ERR_CNT_W-1:0]        err_count
);

  localparam int unsigned SW        = sel_width(NUM_UNITS);
  localparam int unsigned UPPER_LSB = SEL_LSB + SW;
  localparam int unsigned NU_P2     = 1 << SW;
  localparam int unsigned RES_PAD_W = DATA_W * NU_P2;

  logic [STATE_W-1:0]   state_q,     state_d;
  logic [SW-1:0]        sel_q,       sel_d;
  logic [TIMER_W-1:0]   timer_q,     timer_d;
  logic [NUM_UNITS-1:0] unit_req_q,  unit_req_d;
  logic [SEL_LSB-1:0]   unit_opc_q,  unit_opc_d;
  logic [DATA_W-1:0]    unit_op0_q,  unit_op0_d;
  logic [DATA_W-1:0]    unit_op1_q,  unit_op1_d;
  logic [DATA_W-1:0]    result_q,    result_d;
  logic                 complete_q,  complete_d;
  logic                 busy_q,      busy_d;
  logic [ERR_CNT_W-1:0] err_q,       err_d;
  logic                 err_inc_c;

  // Opcode decode: select field plus a must-be-zero field above it.
  logic [SW-1:0] sel_c;
  logic          upper_nz_c;
  logic          mapped_c;

  assign sel_c      = user_opcode[SEL_LSB +: SW];
  assign upper_nz_c = (user_opcode >> UPPER_LSB) != '0;
  assign mapped_c   = !upper_nz_c && (32'(sel_c) < NUM_UNITS);

  // Ack/result of the latched unit; buses padded to a power of two so the
  // select index always covers the vector exactly.
  logic [NU_P2-1:0]     ack_pad_c;
  logic [RES_PAD_W-1:0] res_pad_c;
  logic                 ack_sel_c;
  logic [DATA_W-1:0]    res_sel_c;

  assign ack_pad_c = NU_P2'(unit_ack);
  assign res_pad_c = RES_PAD_W'(unit_result);
  assign ack_sel_c = ack_pad_c[sel_q];
  assign res_sel_c = res_pad_c[DATA_W*sel_q +: DATA_W];

  logic expiry_c;
  assign expiry_c = (timer_q == TIMER_W'(TIMEOUT - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    timer_d    = timer_q;
    unit_req_d = unit_req_q;
    unit_opc_d = unit_opc_q;
    unit_op0_d = unit_op0_q;
    unit_op1_d = unit_op1_q;
    result_d   = '0;
    complete_d = 1'b0;
    err_inc_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (user_valid) begin
          if (mapped_c) begin
            sel_d      = sel_c;
            unit_req_d = NUM_UNITS'(1) << sel_c;
            unit_opc_d = user_opcode[SEL_LSB-1:0];
            unit_op0_d = user_operand_0;
            unit_op1_d = user_operand_1;
            timer_d    = '0;
            state_d    = ST_ISSUE;
          end else begin
            result_d   = ERR_RESULT;
            complete_d = 1'b1;
            err_inc_c  = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end

      ST_ISSUE: begin
        timer_d = timer_q + TIMER_W'(1);
        // An ack landing on the expiry cycle still counts as a good response.
        if (ack_sel_c) begin
          unit_req_d = '0;
          result_d   = res_sel_c;
          complete_d = 1'b1;
          state_d    = ST_RESP;
        end else if (expiry_c) begin
          unit_req_d = '0;
          result_d   = ERR_RESULT;
          complete_d = 1'b1;
          err_inc_c  = 1'b1;
          state_d    = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_WAIT_LOW;
      end

      ST_WAIT_LOW: begin
        // Wait for the CPU to drop valid so a held request is not reissued.
        if (!user_valid) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    err_d  = (err_inc_c && (err_q != '1)) ? err_q + ERR_CNT_W'(1) : err_q;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      timer_q    <= '0;
      unit_req_q <= '0;
      unit_opc_q <= '0;
      unit_op0_q <= '0;
      unit_op1_q <= '0;
      result_q   <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      timer_q    <= timer_d;
      unit_req_q <= unit_req_d;
      unit_opc_q <= unit_opc_d;
      unit_op0_q <= unit_op0_d;
      unit_op1_q <= unit_op1_d;
      result_q   <= result_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign user_result   = result_q;
  assign user_complete = complete_q;
  assign unit_req      = unit_req_q;
  assign unit_opcode   = unit_opc_q;
  assign unit_op0      = unit_op0_q;
  assign unit_op1      = unit_op1_q;
  assign busy          = busy_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_user_insn_dispatch.sv
// Directed bench for user_insn_dispatch (4 units, SEL_LSB 7, TIMEOUT 8).
module tb_user_insn_dispatch;

  logic          clk = 1'b0;
  logic          rst;
  logic          user_valid;
  logic [10:0]   user_opcode;
  logic [31:0]   user_operand_0;
  logic [31:0]   user_operand_1;
  logic [31:0]   user_result;
  logic          user_complete;
  logic [3:0]    unit_req;
  logic [6:0]    unit_opcode;
  logic [31:0]   unit_op0;
  logic [31:0]   unit_op1;
  logic [3:0]    unit_ack;
  logic [127:0]  unit_result;
  logic          busy;
  logic [7:0]    err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  user_insn_dispatch #(
    .NUM_UNITS (4),
    .SEL_LSB   (7),
    .TIMEOUT   (8),
    .ERR_RESULT(32'hDEAD_BEEF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .user_valid    (user_valid),
    .user_opcode   (user_opcode),
    .user_operand_0(user_operand_0),
    .user_operand_1(user_operand_1),
    .user_result   (user_result),
    .user_complete (user_complete),
    .unit_req      (unit_req),
    .unit_opcode   (unit_opcode),
    .unit_op0      (unit_op0),
    .unit_op1      (unit_op1),
    .unit_ack      (unit_ack),
    .unit_result   (unit_result),
    .busy          (busy),
    .err_count     (err_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One CPU transaction, starting at a negedge with the DUT idle. Cycle 1 is
  // the first cycle after valid is sampled. The unit acks in cycle ack_k
  // (0 = never); unit 0 gives a stray ack in cycle wrong_k (0 = none).
  task automatic run_txn(
    input  logic [10:0] opc, input logic [31:0] a, input logic [31:0] b,
    input  int ack_unit, input int ack_k, input logic [31:0] ack_val,
    input  int wrong_k, input int hold,
    output int got_cycle, output logic [31:0] got_result, output logic [3:0] got_req1,
    output int req_cycles, output logic [31:0] post_result, output logic post_complete,
    output logic hold_busy, output logic end_busy);
    for (int i = 0; i < 4; i++) unit_result[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
    user_opcode    = opc;
    user_operand_0 = a;
    user_operand_1 = b;
    user_valid     = 1'b1;
    got_cycle      = 0;
    got_result     = '0;
    got_req1       = '0;
    req_cycles     = 0;
    post_complete  = 1'b0;
    hold_busy      = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      unit_ack = '0;
      if (c == 1) got_req1 = unit_req;
      if (unit_req != 4'b0) req_cycles++;
      if (user_complete) begin
        got_cycle  = c;
        got_result = user_result;
        break;
      end
      if (c == ack_k) begin
        unit_ack[ack_unit] = 1'b1;
        unit_result[32*ack_unit +: 32] = ack_val;
      end
      if (c == wrong_k) begin
        unit_ack[0] = 1'b1;
        unit_result[31:0] = 32'h1111_1111;
      end
    end
    unit_ack = '0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (unit_req != 4'b0) req_cycles++;
      post_complete = post_complete | user_complete;
      hold_busy = busy;
    end
    user_valid = 1'b0;
    @(negedge clk);
    post_result   = user_result;
    post_complete = post_complete | user_complete;
    if (unit_req != 4'b0) req_cycles++;
    @(negedge clk);
    end_busy = busy;
  endtask

  typedef struct {
    logic [10:0] opc;
    logic [31:0] a;
    logic [31:0] b;
    int          ack_unit;
    int          ack_k;
    logic [31:0] ack_val;
    logic [3:0]  exp_req;
    int          exp_cycle;
    logic [31:0] exp_result;
    logic [6:0]  exp_uopc;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[7];

  int          got_cycle, req_cycles;
  logic [31:0] got_result, post_result;
  logic [3:0]  got_req1;
  logic        post_complete, hold_busy, end_busy;
  logic [31:0] last_a, last_b;

  initial begin
    vecs[0] = '{11'h085, 32'd1,  32'd2,  1, 4, 32'h0000_1234, 4'b0010, 5, 32'h0000_1234, 7'h05, 8'd0};
    vecs[1] = '{11'h103, 32'd10, 32'd20, 2, 0, 32'h0,         4'b0100, 9, 32'hDEAD_BEEF, 7'h03, 8'd1};
    vecs[2] = '{11'h400, 32'd30, 32'd40, 0, 0, 32'h0,         4'b0000, 1, 32'hDEAD_BEEF, 7'h03, 8'd2};
    vecs[3] = '{11'h17F, 32'd50, 32'd60, 2, 1, 32'hCAFE_F00D, 4'b0100, 2, 32'hCAFE_F00D, 7'h7F, 8'd2};
    vecs[4] = '{11'h000, 32'd70, 32'd80, 0, 8, 32'h5555_AAAA, 4'b0001, 9, 32'h5555_AAAA, 7'h00, 8'd2};
    vecs[5] = '{11'h200, 32'd90, 32'd99, 0, 0, 32'h0,         4'b0000, 1, 32'hDEAD_BEEF, 7'h00, 8'd3};
    vecs[6] = '{11'h1FF, 32'hFFFF_FFFF, 32'h8000_0001, 3, 2, 32'h0BAD_CAFE, 4'b1000, 3, 32'h0BAD_CAFE, 7'h7F, 8'd3};

    rst = 1'b1;
    user_valid = 1'b0;
    user_opcode = '0;
    user_operand_0 = '0;
    user_operand_1 = '0;
    unit_ack = '0;
    unit_result = '0;
    last_a = '0;
    last_b = '0;
    repeat (2) @(negedge clk);
    check("reset user_complete", 32'(user_complete), 32'd0);
    check("reset user_result", user_result, 32'd0);
    check("reset unit_req", 32'(unit_req), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    check("reset unit_opcode", 32'(unit_opcode), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].ack_unit, vecs[i].ack_k,
              vecs[i].ack_val, 0, 0, got_cycle, got_result, got_req1, req_cycles,
              post_result, post_complete, hold_busy, end_busy);
      if (vecs[i].exp_req != 4'b0) begin
        last_a = vecs[i].a;
        last_b = vecs[i].b;
      end
      check($sformatf("v%0d complete_cycle", i), 32'(got_cycle), 32'(vecs[i].exp_cycle));
      check($sformatf("v%0d user_result", i), got_result, vecs[i].exp_result);
      check($sformatf("v%0d unit_req", i), 32'(got_req1), 32'(vecs[i].exp_req));
      check($sformatf("v%0d req_cycles", i), 32'(req_cycles), 32'(vecs[i].exp_cycle - 1));
      check($sformatf("v%0d unit_opcode", i), 32'(unit_opcode), 32'(vecs[i].exp_uopc));
      check($sformatf("v%0d unit_op0", i), unit_op0, last_a);
      check($sformatf("v%0d unit_op1", i), unit_op1, last_b);
      check($sformatf("v%0d err_count", i), 32'(err_count), 32'(vecs[i].exp_err));
      check($sformatf("v%0d result_after", i), post_result, 32'd0);
      check($sformatf("v%0d extra_complete", i), 32'(post_complete), 32'd0);
      check($sformatf("v%0d idle_after", i), 32'(end_busy), 32'd0);
    end

    // Stray ack from unit 0 while unit 2 is selected, then the real ack.
    run_txn(11'h105, 32'd5, 32'd6, 2, 3, 32'h0000_A5A5, 2, 0, got_cycle, got_result,
            got_req1, req_cycles, post_result, post_complete, hold_busy, end_busy);
    check("wrong_ack complete_cycle", 32'(got_cycle), 32'd4);
    check("wrong_ack user_result", got_result, 32'h0000_A5A5);
    check("wrong_ack err_count", 32'(err_count), 32'd3);

    // Ack arriving on the timeout cycle beats the timeout.
    run_txn(11'h105, 32'd7, 32'd8, 2, 8, 32'h0000_A5A5, 0, 0, got_cycle, got_result,
            got_req1, req_cycles, post_result, post_complete, hold_busy, end_busy);
    check("expiry_ack complete_cycle", 32'(got_cycle), 32'd9);
    check("expiry_ack user_result", got_result, 32'h0000_A5A5);
    check("expiry_ack err_count", 32'(err_count), 32'd3);

    // Valid held for 5 cycles after completion: one request only.
    run_txn(11'h085, 32'd11, 32'd12, 1, 1, 32'h0000_0077, 0, 5, got_cycle, got_result,
            got_req1, req_cycles, post_result, post_complete, hold_busy, end_busy);
    check("held complete_cycle", 32'(got_cycle), 32'd2);
    check("held user_result", got_result, 32'h0000_0077);
    check("held req_cycles", 32'(req_cycles), 32'd1);
    check("held extra_complete", 32'(post_complete), 32'd0);
    check("held busy_in_wait", 32'(hold_busy), 32'd1);
    check("held idle_after", 32'(end_busy), 32'd0);

    // Saturation of the error counter with a stream of unmapped opcodes.
    for (int n = 0; n < 260; n++) begin
      run_txn(11'h600, 32'd0, 32'd0, 0, 0, 32'h0, 0, 0, got_cycle, got_result,
              got_req1, req_cycles, post_result, post_complete, hold_busy, end_busy);
    end
    check("saturate err_count", 32'(err_count), 32'h0000_00FF);
    check("saturate last_result", got_result, 32'hDEAD_BEEF);

    // Reset in the middle of an issue: request and busy clear at once.
    user_opcode = 11'h085;
    user_operand_0 = 32'd3;
    user_operand_1 = 32'd4;
    user_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset req_before", 32'(unit_req), 32'b0010);
    #2 rst = 1'b1;
    #1;
    check("midreset req", 32'(unit_req), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset err_count", 32'(err_count), 32'd0);
    user_valid = 1'b0;
    @(negedge clk);
    check("midreset complete", 32'(user_complete), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midreset complete_after", 32'(user_complete), 32'd0);
    run_txn(11'h085, 32'd1, 32'd2, 1, 4, 32'h0000_1234, 0, 0, got_cycle, got_result,
            got_req1, req_cycles, post_result, post_complete, hold_busy, end_busy);
    check("postreset complete_cycle", 32'(got_cycle), 32'd5);
    check("postreset user_result", got_result, 32'h0000_1234);
    check("postreset unit_req", 32'(got_req1), 32'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
